// File: rtl/rom_fetch_master_if.sv
// Single-way synchronous RAM/ROM port: the master drives a word address and
// the slave returns the addressed word one clock later.
interface if_ram_1way #(
  parameter int unsigned ADDR_WIDTH = 10
) ();

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_rdata;

  modport MASTER (output ram_addr, input ram_rdata);
  modport SLAVE  (input ram_addr, output ram_rdata);

endinterface : if_ram_1way

// File: rtl/rom_fetch_master.sv
// Sequential instruction fetcher in front of a 1-cycle-latency ROM.
// One ROM request may be in flight; its response lands in a 2-entry buffer
// that feeds the core through a valid/ready stream. A request is only issued
// when buffer occupancy plus the in-flight word leaves room for it, so the
// buffer can never overflow. A jump flushes the buffer, squashes the
// in-flight response and restarts fetching at the target address.
module rom_fetch_master #(
  parameter logic [31:0]  RESET_ADDR = 32'h0000_0000,
  parameter int unsigned  ADDR_WIDTH = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_addr_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  if_ram_1way.MASTER  if_rom
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_addr_q, inflight_addr_d;

  // Two-entry output buffer, addressed by 1-bit read/write pointers.
  logic [31:0] buf_addr_q [2];
  logic [31:0] buf_addr_d [2];
  logic [31:0] buf_data_q [2];
  logic [31:0] buf_data_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        pop_s;
  logic        push_s;
  logic        issue_s;
  logic [2:0]  occupancy_s;

  // Byte-offset bits of a jump target carry no information for word fetches.
  logic        jmp_lsb_unused_s;
  assign jmp_lsb_unused_s = ^jmp_addr_i[1:0];

  // The ROM always sees the current pc; only issue cycles are real requests.
  assign if_rom.ram_addr = pc_q[ADDR_WIDTH+1:2];

  assign instr_valid_o = (count_q != 2'd0);

  // Handshake, credit and capture decisions for this cycle.
  always_comb begin
    pop_s       = instr_valid_o && instr_ready_i;
    occupancy_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s     = (state_q == ST_RUN) && fetch_en_i && !jmp_i && (occupancy_s < 3'd2);
    // A response arriving in a jump cycle belongs to the old path.
    push_s      = inflight_q && !jmp_i;
  end

  // Run/idle control: fetching stops as soon as fetch_en_i drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_en_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!fetch_en_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Program counter and in-flight request tracking; jumps win over issue.
  always_comb begin
    pc_d            = pc_q;
    inflight_d      = issue_s;
    inflight_addr_d = inflight_addr_q;
    if (jmp_i) begin
      pc_d = {jmp_addr_i[31:2], 2'b00};
    end else if (issue_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
    if (issue_s) begin
      inflight_addr_d = pc_q;
    end else begin
      inflight_addr_d = inflight_addr_q;
    end
  end

  // Buffer push/pop bookkeeping; a jump empties the buffer outright.
  always_comb begin
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (jmp_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_s) begin
        buf_addr_d[wr_ptr_q] = inflight_addr_q;
        buf_data_d[wr_ptr_q] = if_rom.ram_rdata;
        wr_ptr_d             = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Head of the buffer drives the stream; outputs read zero when empty.
  always_comb begin
    if (instr_valid_o) begin
      instr_o      = buf_data_q[rd_ptr_q];
      instr_addr_o = buf_addr_q[rd_ptr_q];
    end else begin
      instr_o      = 32'd0;
      instr_addr_o = 32'd0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_ADDR;
      inflight_q      <= 1'b0;
      inflight_addr_q <= 32'd0;
      buf_addr_q[0]   <= 32'd0;
      buf_addr_q[1]   <= 32'd0;
      buf_data_q[0]   <= 32'd0;
      buf_data_q[1]   <= 32'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      buf_addr_q      <= buf_addr_d;
      buf_data_q      <= buf_data_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

endmodule : rom_fetch_master

// File: tb/tb_rom_fetch_master.sv
// Self-checking bench for rom_fetch_master: ROM model, stream scoreboard,
// a table of redirect vectors and hand-written multi-cycle sequences.
module tb_rom_fetch_master;

  localparam int unsigned AW = 10;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_valid;

  if_ram_1way #(.ADDR_WIDTH(AW)) rom_if ();

  rom_fetch_master #(
    .RESET_ADDR (32'h0000_0000),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_en_i    (fetch_en),
    .jmp_i         (jmp),
    .jmp_addr_i    (jmp_addr),
    .instr_o       (instr),
    .instr_addr_o  (instr_addr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (ready),
    .if_rom        (rom_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word k holds 32'hA000_0000 + k, read latency one cycle.
  always @(posedge clk) begin
    rom_if.ram_rdata <= 32'hA000_0000 + {22'd0, rom_if.ram_addr};
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } word_t;

  word_t exp_q[$];
  word_t sb_w;
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + {22'd0, a[11:2]};
  endfunction

  task automatic expect_stream(input logic [31:0] start, input int n);
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      exp_q.push_back({a, rom_word(a)});
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted word must be the next expected one.
  always @(negedge clk) begin
    if (!rst && instr_valid && ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got addr=%h data=%h, required no word", instr_addr, instr);
      end else begin
        sb_w = exp_q.pop_front();
        if ({instr_addr, instr} !== sb_w) begin
          n_bad++;
          $display("FAIL sb_word: got addr=%h data=%h, required addr=%h data=%h",
                   instr_addr, instr, sb_w.addr, sb_w.data);
        end
      end
    end
  end

  typedef struct {
    logic [31:0] jaddr;
    logic [31:0] first_addr;
    logic [31:0] first_data;
  } jvec_t;

  jvec_t       vt [4];
  logic [31:0] hold_addr;
  logic [31:0] hold_data;
  logic [31:0] hold_ram;

  // Checks the three-cycle startup/redirect latency and the first word.
  task automatic chk_latency(input string tag, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    chk({tag, "_lat0"}, {31'd0, instr_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk({tag, "_lat1"}, {31'd0, instr_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk({tag, "_lat2"}, {31'd0, instr_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_addr"}, instr_addr, a);
    chk({tag, "_data"}, instr, d);
    cyc();
  endtask

  // Runs n cycles of an uninterrupted stream, checking for bubbles.
  task automatic run_stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_nobubble"}, {31'd0, instr_valid}, 32'd1);
      cyc();
    end
  endtask

  initial begin
    vt[0] = '{jaddr: 32'h0000_0200, first_addr: 32'h0000_0200, first_data: 32'hA000_0080};
    vt[1] = '{jaddr: 32'h0000_0FFA, first_addr: 32'h0000_0FF8, first_data: 32'hA000_03FE};
    vt[2] = '{jaddr: 32'hFFFF_FFFD, first_addr: 32'hFFFF_FFFC, first_data: 32'hA000_03FF};
    vt[3] = '{jaddr: 32'h0000_0007, first_addr: 32'h0000_0004, first_data: 32'hA000_0001};

    rst = 1'b1; fetch_en = 1'b0; jmp = 1'b0; jmp_addr = 32'd0; ready = 1'b1;
    cyc();
    cyc();

    // Reset state.
    @(negedge clk);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_iaddr", instr_addr, 32'd0);
    chk("rst_ramaddr", {22'd0, rom_if.ram_addr}, 32'd0);
    cyc();

    // Startup: enable at E, issue at E+1, valid at E+3, then no bubbles.
    rst = 1'b0; fetch_en = 1'b1;
    expect_stream(32'h0, 64);
    chk_latency("start", 32'h0000_0000, 32'hA000_0000);
    run_stream("start", 5);

    // Consumer stall for 5 cycles: head held, no new ROM requests.
    ready = 1'b0;
    @(negedge clk);
    hold_addr = instr_addr; hold_data = instr; hold_ram = {22'd0, rom_if.ram_addr};
    cyc();
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_addr_hold", instr_addr, hold_addr);
      chk("stall_data_hold", instr, hold_data);
      chk("stall_no_request", {22'd0, rom_if.ram_addr}, hold_ram);
      cyc();
    end
    ready = 1'b1;
    run_stream("resume", 6);

    // Jump while the buffer and in-flight slot are occupied and core stalls.
    ready = 1'b0; jmp = 1'b1; jmp_addr = 32'h0000_0103;
    cyc();
    jmp = 1'b0; ready = 1'b1;
    expect_stream(32'h0000_0100, 64);
    @(negedge clk);
    chk("jfull_flushed", {31'd0, instr_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("jfull_lat2", {31'd0, instr_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("jfull_valid", {31'd0, instr_valid}, 32'd1);
    chk("jfull_addr", instr_addr, 32'h0000_0100);
    chk("jfull_data", instr, 32'hA000_0040);
    cyc();
    run_stream("jfull", 4);

    // Table of jumps taken in the same cycle as a pop.
    for (int v = 0; v < 4; v++) begin
      jmp = 1'b1; jmp_addr = vt[v].jaddr;
      @(negedge clk);
      chk("jpop_popped", {31'd0, instr_valid}, 32'd1);
      cyc();
      jmp = 1'b0;
      expect_stream(vt[v].first_addr, 64);
      @(negedge clk);
      chk("jpop_no_stale", {31'd0, instr_valid}, 32'd0);
      cyc();
      @(negedge clk);
      chk("jpop_lat2", {31'd0, instr_valid}, 32'd0);
      cyc();
      @(negedge clk);
      chk("jpop_valid", {31'd0, instr_valid}, 32'd1);
      chk("jpop_addr", instr_addr, vt[v].first_addr);
      chk("jpop_data", instr, vt[v].first_data);
      cyc();
      run_stream("jpop", 4);
    end

    // fetch_en dropped for 4 cycles: pending words drain, pc frozen.
    fetch_en = 1'b0;
    @(negedge clk);
    hold_ram = {22'd0, rom_if.ram_addr};
    cyc();
    @(negedge clk);
    chk("fen_drain_valid", {31'd0, instr_valid}, 32'd1);
    chk("fen_no_request", {22'd0, rom_if.ram_addr}, hold_ram);
    cyc();
    for (int k = 2; k < 4; k++) begin
      @(negedge clk);
      chk("fen_drained", {31'd0, instr_valid}, 32'd0);
      chk("fen_no_request", {22'd0, rom_if.ram_addr}, hold_ram);
      cyc();
    end
    fetch_en = 1'b1;
    @(negedge clk);
    chk("fen_restart_lat0", {31'd0, instr_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("fen_restart_lat1", {31'd0, instr_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("fen_restart_lat2", {31'd0, instr_valid}, 32'd0);
    cyc();
    run_stream("fen_restart", 4);

    // Reset mid-stream: outputs clear at once, restart from RESET_ADDR.
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst_instr", instr, 32'd0);
    chk("mrst_iaddr", instr_addr, 32'd0);
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
    expect_stream(32'h0, 64);
    chk_latency("mrst", 32'h0000_0000, 32'hA000_0000);
    run_stream("mrst", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rom_fetch_master
